// File: rtl/dcfeb_link_pkg.sv
// Shared constants, state encoding and PRBS-15 step function for the DCFEB
// comparator optical link (used by both the TX framer and the OTMB receiver).
package dcfeb_link_pkg;

    localparam logic [7:0]  COMMA_K28_5   = 8'hBC;
    localparam logic [7:0]  HDR_DATA_DEF  = 8'h50;
    localparam logic [7:0]  HDR_FC_DEF    = 8'hFC;
    localparam logic [7:0]  HDR_START_DEF = 8'hB7;
    localparam logic [47:0] START_PAT_DEF = 48'hC3C3_5A5A_A5A5;
    localparam logic [14:0] PRBS_SEED     = 15'h7FFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } link_state_t;

    typedef struct packed {
        logic [14:0] state;
        logic [15:0] word;
    } prbs_step_t;

    // Sixteen serial steps of x^15+x^14+1; the first generated bit lands in
    // word[15], the last in word[0].
    function automatic prbs_step_t prbs15_step16(input logic [14:0] s);
        prbs_step_t  r;
        logic [14:0] st;
        logic        nb;
        st     = s;
        r.word = '0;
        for (int i = 15; i >= 0; i--) begin
            nb        = st[14] ^ st[13];
            st        = {st[13:0], nb};
            r.word[i] = nb;
        end
        r.state = st;
        return r;
    endfunction

endpackage

// File: rtl/prbs15_gen16.sv
// 16-bit parallel PRBS-15 generator: word is valid combinationally from the
// current LFSR state; adv moves to the next 16 bits, load reseeds.
module prbs15_gen16
    import dcfeb_link_pkg::*;
(
    input  logic        clock,
    input  logic        rst_n,
    input  logic        load,
    input  logic        adv,
    output logic [15:0] word
);

    logic [14:0] lfsr;
    prbs_step_t  step;

    // Next 16 bits and the LFSR state that follows them.
    always_comb begin
        step = prbs15_step16(lfsr);
    end

    assign word = step.word;

    // LFSR register: reseed has priority over advance, otherwise hold.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= PRBS_SEED;
        end else if (load) begin
            lfsr <= PRBS_SEED;
        end else if (adv) begin
            lfsr <= step.state;
        end
    end

endmodule

// File: rtl/gtx_comp_frame_tx.sv
// DCFEB comparator link TX framer: four 16-bit words per BX (comma/header
// word then three payload words) on the 160 MHz GTX word clock.
//
// Handshake: dat_ack is a strobe with no backpressure. It is high during the
// cycle whose closing clock edge samples comp_dat; the source must present
// valid comp_dat in that cycle. It only fires in RUN, once per frame.
module gtx_comp_frame_tx
    import dcfeb_link_pkg::*;
#(
    parameter int unsigned START_FRAMES = 64,
    parameter logic [7:0]  HDR_DATA     = HDR_DATA_DEF,
    parameter logic [7:0]  HDR_FC       = HDR_FC_DEF,
    parameter logic [7:0]  HDR_START    = HDR_START_DEF,
    parameter logic [47:0] START_PAT    = START_PAT_DEF
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        tx_ready,
    input  logic        tx_enable,
    input  logic        prbs_en,
    input  logic        fc_req,
    input  logic        inj_err,
    input  logic [47:0] comp_dat,
    output logic        dat_ack,
    output logic [15:0] tx_data,
    output logic [1:0]  tx_charisk,
    output logic        frame_start,
    output logic        run,
    output logic [15:0] frame_count
);

    localparam logic [7:0] START_LAST = 8'(START_FRAMES - 1);

    logic [1:0]  phase;
    link_state_t state, state_next;
    logic [7:0]  start_cnt, start_cnt_next;
    logic [47:0] hold;
    logic        prbs_q, fc_pend, err_pend, frame_err;
    logic        run_word0, prbs_load, prbs_adv;
    logic [15:0] prbs_word, payload_word, word;
    logic [7:0]  hdr;
    logic [1:0]  charisk;

    function automatic logic [15:0] payload_slice(input logic [47:0] p, input logic [1:0] ph);
        case (ph)
            2'd1:    return p[15:0];
            2'd2:    return p[31:16];
            2'd3:    return p[47:32];
            default: return 16'h0000;
        endcase
    endfunction

    assign run_word0 = (state == ST_RUN) && (phase == 2'd0);
    assign prbs_adv  = (state == ST_RUN) && prbs_q && (phase != 2'd0);
    assign prbs_load = (phase == 2'd3) && (state == ST_RUN) && (state_next != ST_RUN);

    prbs15_gen16 u_prbs (
        .clock (clock),
        .rst_n (rst_n),
        .load  (prbs_load),
        .adv   (prbs_adv),
        .word  (prbs_word)
    );

    // FSM state register and start-frame counter.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            start_cnt <= 8'd0;
        end else begin
            state     <= state_next;
            start_cnt <= start_cnt_next;
        end
    end

    // Next state: only decided on the last word of a frame so frames never split.
    always_comb begin
        state_next     = state;
        start_cnt_next = start_cnt;
        if (phase == 2'd3) begin
            if (!(tx_ready && tx_enable)) begin
                state_next     = ST_IDLE;
                start_cnt_next = 8'd0;
            end else begin
                case (state)
                    ST_IDLE: state_next = ST_START;
                    ST_START: begin
                        if (start_cnt == START_LAST) begin
                            state_next     = ST_RUN;
                            start_cnt_next = 8'd0;
                        end else begin
                            start_cnt_next = start_cnt + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Phase, BX data capture, per-frame mode flags and sticky requests.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            phase       <= 2'd0;
            frame_count <= 16'd0;
            hold        <= 48'd0;
            prbs_q      <= 1'b0;
            fc_pend     <= 1'b0;
            err_pend    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            phase    <= phase + 2'd1;
            // A request arriving while word0 is being built waits for the next frame.
            fc_pend  <= (fc_pend  && !run_word0) || fc_req;
            err_pend <= (err_pend && !run_word0) || inj_err;
            if (phase == 2'd0) begin
                frame_err <= run_word0 && err_pend;
            end
            if (run_word0) begin
                frame_count <= frame_count + 16'd1;
            end
            if (phase == 2'd3) begin
                prbs_q <= prbs_en;
                if (state == ST_RUN) begin
                    hold <= comp_dat;
                end
            end
        end
    end

    // Word for the current phase, selected by the state of this frame.
    always_comb begin
        hdr          = 8'h00;
        payload_word = 16'h0000;
        word         = 16'h0000;
        charisk      = 2'b00;
        case (state)
            ST_START: begin
                hdr          = HDR_START;
                payload_word = payload_slice(START_PAT, phase);
            end
            ST_RUN: begin
                hdr          = fc_pend ? HDR_FC : HDR_DATA;
                payload_word = prbs_q ? prbs_word : payload_slice(hold, phase);
            end
            default: ;
        endcase
        if (phase == 2'd0) begin
            word    = {hdr, COMMA_K28_5};
            charisk = 2'b01;
        end else if (phase == 2'd1) begin
            word = payload_word ^ {15'd0, frame_err};
        end else begin
            word = payload_word;
        end
    end

    // Registered GTX-facing outputs, aligned with the word on tx_data.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            tx_data     <= {8'h00, COMMA_K28_5};
            tx_charisk  <= 2'b01;
            frame_start <= 1'b0;
            dat_ack     <= 1'b0;
            run         <= 1'b0;
        end else begin
            tx_data     <= word;
            tx_charisk  <= charisk;
            frame_start <= (phase == 2'd0);
            dat_ack     <= (state == ST_RUN) && (phase == 2'd2);
            run         <= (state == ST_RUN);
        end
    end

endmodule

// File: tb/tb_gtx_comp_frame_tx.sv
// Directed bench for gtx_comp_frame_tx: captures whole frames and compares
// them with hand-computed words and a stream-recurrence PRBS-15 reference.
module tb_gtx_comp_frame_tx;

    localparam logic [47:0] C0 = 48'h1234_5678_9ABC;
    localparam logic [47:0] C1 = 48'h0F1E_2D3C_4B5A;
    localparam logic [47:0] C2 = 48'hFFFF_0000_8001;
    localparam logic [47:0] SP = 48'hC3C3_5A5A_A5A5;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        tx_ready, tx_enable, prbs_en, fc_req, inj_err;
    logic [47:0] comp_dat;
    logic        dat_ack, frame_start, run;
    logic [15:0] tx_data, frame_count;
    logic [1:0]  tx_charisk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          exp_cnt = 0;
    int          ack_cyc = 0;
    int          lat_meas = 0;
    logic [15:0] fw [4];
    logic [1:0]  fk [4];
    logic [3:0]  fs_v, ack_v, run_v;
    logic [15:0] fcnt;
    logic [15:0] prbs_ref [9];
    logic [158:0] pb;

    // Clock and reset block
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected run to finish");
        $fatal(1, "watchdog");
    end

    gtx_comp_frame_tx #(.START_FRAMES(4)) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .tx_ready    (tx_ready),
        .tx_enable   (tx_enable),
        .prbs_en     (prbs_en),
        .fc_req      (fc_req),
        .inj_err     (inj_err),
        .comp_dat    (comp_dat),
        .dat_ack     (dat_ack),
        .tx_data     (tx_data),
        .tx_charisk  (tx_charisk),
        .frame_start (frame_start),
        .run         (run),
        .frame_count (frame_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Capture the next whole frame; optional pulses at phase 1 / phase 2 and
    // a tx_ready drop at phase 1 of that frame.
    task automatic grab_frame(input logic fc1, input logic err1, input logic fc2, input logic drop1);
        do tick(); while ((cyc % 4) != 1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            if (i == 1) lat_meas = cyc - ack_cyc;
            fw[i]    = tx_data;
            fk[i]    = tx_charisk;
            fs_v[i]  = frame_start;
            ack_v[i] = dat_ack;
            run_v[i] = run;
            if (dat_ack) ack_cyc = cyc;
            if (i == 0) begin
                fcnt    = frame_count;
                fc_req  = fc1;
                inj_err = err1;
                if (drop1) tx_ready = 1'b0;
            end else if (i == 1) begin
                fc_req  = fc2;
                inj_err = 1'b0;
            end else begin
                fc_req  = 1'b0;
                inj_err = 1'b0;
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic is_run, input logic [7:0] hdr,
                               input logic [47:0] pay, input logic chk_pay);
        if (is_run) exp_cnt++;
        check({tag, ".w0"}, 64'(fw[0]), 64'({hdr, 8'hBC}));
        if (chk_pay) begin
            check({tag, ".w1"}, 64'(fw[1]), 64'(pay[15:0]));
            check({tag, ".w2"}, 64'(fw[2]), 64'(pay[31:16]));
            check({tag, ".w3"}, 64'(fw[3]), 64'(pay[47:32]));
        end
        check({tag, ".k"}, 64'({fk[0], fk[1], fk[2], fk[3]}), 64'(8'b01_00_00_00));
        check({tag, ".fs"}, 64'(fs_v), 64'(4'b0001));
        check({tag, ".ack"}, 64'(ack_v), is_run ? 64'(4'b0100) : 64'(4'b0000));
        check({tag, ".run"}, 64'(run_v), is_run ? 64'(4'b1111) : 64'(4'b0000));
        check({tag, ".cnt"}, 64'(fcnt), 64'(exp_cnt));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".data"}, 64'(tx_data), 64'(16'h00BC));
        check({tag, ".k"}, 64'(tx_charisk), 64'(2'b01));
        check({tag, ".fs"}, 64'(frame_start), 64'(0));
        check({tag, ".ack"}, 64'(dat_ack), 64'(0));
        check({tag, ".run"}, 64'(run), 64'(0));
        check({tag, ".cnt"}, 64'(frame_count), 64'(0));
    endtask

    initial begin
        // PRBS-15 reference as a bit stream: the 15 bits before the first
        // output are the all-ones seed, then b[n] = b[n-15] ^ b[n-14].
        for (int n = 0; n < 15; n++) pb[n] = 1'b1;
        for (int n = 15; n < 159; n++) pb[n] = pb[n-15] ^ pb[n-14];
        for (int w = 0; w < 9; w++)
            for (int j = 0; j < 16; j++)
                prbs_ref[w][15-j] = pb[15 + 16*w + j];

        rst_n = 1'b0; tx_ready = 1'b0; tx_enable = 1'b0; prbs_en = 1'b0;
        fc_req = 1'b0; inj_err = 1'b0; comp_dat = 48'd0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        cyc   = 0;

        grab_frame(0, 0, 0, 0); check_frame("idle0", 0, 8'h00, 48'd0, 1);
        grab_frame(0, 0, 0, 0); check_frame("idle1", 0, 8'h00, 48'd0, 1);

        tx_ready = 1'b1; tx_enable = 1'b1; comp_dat = C0;
        grab_frame(0, 0, 0, 0); check_frame("idle2", 0, 8'h00, 48'd0, 1);
        for (int s = 0; s < 4; s++) begin
            grab_frame(0, 0, 0, 0); check_frame("start", 0, 8'hB7, SP, 1);
        end
        grab_frame(0, 0, 0, 0); check_frame("run0", 1, 8'h50, 48'd0, 0);

        comp_dat = C1;
        grab_frame(0, 0, 0, 0); check_frame("data0", 1, 8'h50, C0, 1);
        check("ack_to_w1", 64'(lat_meas), 64'(3));
        comp_dat = C2;
        grab_frame(1, 0, 0, 0); check_frame("data1", 1, 8'h50, C1, 1);
        grab_frame(0, 0, 0, 0); check_frame("fc_hdr", 1, 8'hFC, C2, 1);
        grab_frame(1, 1, 1, 0); check_frame("pre_both", 1, 8'h50, C2, 1);
        grab_frame(0, 0, 0, 0); check_frame("both", 1, 8'hFC, C2 ^ 48'h1, 1);
        grab_frame(0, 0, 0, 0); check_frame("post_both", 1, 8'h50, C2, 1);

        prbs_en = 1'b1;
        grab_frame(0, 0, 0, 0); check_frame("prbs_off", 1, 8'h50, C2, 1);
        grab_frame(0, 0, 0, 0); check_frame("prbs0", 1, 8'h50, {prbs_ref[2], prbs_ref[1], prbs_ref[0]}, 1);
        grab_frame(0, 0, 0, 0); check_frame("prbs1", 1, 8'h50, {prbs_ref[5], prbs_ref[4], prbs_ref[3]}, 1);
        tx_enable = 1'b0;
        grab_frame(0, 0, 0, 0); check_frame("prbs2", 1, 8'h50, {prbs_ref[8], prbs_ref[7], prbs_ref[6]}, 1);
        tx_enable = 1'b1;
        grab_frame(0, 0, 0, 0); check_frame("idle3", 0, 8'h00, 48'd0, 1);
        for (int s = 0; s < 4; s++) begin
            grab_frame(0, 0, 0, 0); check_frame("restart", 0, 8'hB7, SP, 1);
        end
        grab_frame(0, 0, 0, 0); check_frame("reprbs0", 1, 8'h50, {prbs_ref[2], prbs_ref[1], prbs_ref[0]}, 1);
        grab_frame(0, 0, 0, 1); check_frame("reprbs1", 1, 8'h50, {prbs_ref[5], prbs_ref[4], prbs_ref[3]}, 1);
        grab_frame(0, 0, 0, 0); check_frame("idle4", 0, 8'h00, 48'd0, 1);

        tick(); tick();
        check("mid.data", 64'(tx_data), 64'(16'h0000));
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gtx_comp_frame_tx.md
Name: gtx_comp_frame_tx

Overview:
- Transmit-side framer for the DCFEB comparator optical link: the generator of the frames that the OTMB GTX comparator receiver decodes.
- Takes 48-bit comparator data once per bunch crossing (BX) and serializes it as four 16-bit words per BX: one comma/header word and three data words.
- Provides the start pattern, the "FC" latency marker, PRBS test data and single-frame error injection.
- Drives the 16-bit parallel TX port of a GTX transmitter wrapper, running on the 160 MHz word clock.

Parameters:
- START_FRAMES, 64, number of start-pattern frames sent before entering RUN (range 1-255).
- HDR_DATA, 8'h50, header byte for a normal data frame.
- HDR_FC, 8'hFC, header byte for a latency-marker frame.
- HDR_START, 8'hB7, header byte for a start-pattern frame.
- START_PAT, 48'hC3C3_5A5A_A5A5, data payload of start frames.

Ports:
- clock, in, 1, 160 MHz TX word clock (4x LHC clock, phase-locked).
- rst_n, in, 1, asynchronous active-low reset.
- tx_ready, in, 1, GTX TX reset/PLL done; low forces IDLE.
- tx_enable, in, 1, software enable for data transmission.
- prbs_en, in, 1, replace comparator data with PRBS-15.
- fc_req, in, 1, one-cycle request to mark the next frame with HDR_FC.
- inj_err, in, 1, one-cycle request to invert bit 0 of word1 in the next frame.
- comp_dat, in, 48, comparator data for the current BX.
- dat_ack, out, 1, pulse: comp_dat sampled this cycle.
- tx_data, out, 16, word to GTX TXDATA.
- tx_charisk, out, 2, GTX TXCHARISK.
- frame_start, out, 1, tx_data currently holds word0.
- run, out, 1, FSM is in RUN.
- frame_count, out, 16, frames sent in RUN; wraps.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Registers: phase=0, state=IDLE, start_cnt=0, frame_count=0, PRBS state=15'h7FFF.
  - Outputs: tx_data=16'h00BC, tx_charisk=2'b01, frame_start=0, dat_ack=0, run=0.
  - Pending fc/err flags cleared.
- Phase counter:
  - 2-bit phase increments every clock in all states and wraps 3->0.
  - Word index = phase.
  - Outputs are registered, so a word appears on tx_data one cycle after its phase is evaluated.
  - frame_start=1 exactly when tx_data holds word0.
- Frame format:
  - word0 = {hdr[7:0], 8'hBC}, charisk 2'b01.
  - word1 = payload[15:0], word2 = payload[31:16], word3 = payload[47:32], charisk 2'b00.
- FSM state changes only when phase==3, so frames are never split:
  - IDLE: hdr=8'h00, payload=0. Go to START if tx_ready & tx_enable.
  - START: hdr=HDR_START, payload=START_PAT. start_cnt increments per frame. Go to RUN after START_FRAMES frames; start_cnt then clears.
  - RUN: hdr=HDR_DATA or HDR_FC, payload=held data.
  - Any state: go to IDLE if !tx_ready or !tx_enable, evaluated at phase 3.
  - tx_ready falling mid-frame: finish the current frame, then emit an IDLE frame.
- Data path:
  - In RUN with phase==3, comp_dat is latched into a holding register and dat_ack=1 that cycle.
  - That value is transmitted in words1-3 of the following frame.
  - Latency from sampling to word1 on tx_data is 3 clocks.
  - dat_ack=0 outside RUN.
- PRBS:
  - prbs_en is sampled at phase 3 and applies to the next frame.
  - When set, words1-3 take successive PRBS-15 outputs (x^15+x^14+1, 16 bits per word, LFSR advanced 16 steps per word).
  - comp_dat is ignored, but dat_ack still pulses.
  - LFSR holds when not used; it reseeds to 7FFF on leaving RUN.
- fc_req:
  - Sets a sticky pending flag.
  - The next RUN frame whose word0 is built after the request uses HDR_FC; the flag clears when that word0 is issued.
  - Multiple requests before issue merge into one.
  - Requests outside RUN are held until RUN.
- inj_err: same sticky semantics as fc_req; inverts payload bit 0 (word1 bit 0) of one RUN frame.
- Simultaneous fc_req and inj_err: both apply to the same frame.
- frame_count increments at each RUN word0, wraps FFFF->0000, and is not cleared by leaving RUN (only by reset).

Decomposition:
- Shared package (dcfeb_link_pkg): COMMA_K28_5=8'hBC, HDR_DATA/HDR_FC/HDR_START defaults, START_PAT, state encoding {IDLE, START, RUN}, and the PRBS-15 next-state function.
- The receiver uses the same package constants.
- One sub-module: prbs15_gen16 (16-bit parallel PRBS-15, seed load, advance enable).

Test Plan:
- Reset release with tx_ready=0: tx_data alternates 00BC/0000/0000/0000, charisk 01/00/00/00, run=0, dat_ack never high.
- tx_ready=tx_enable=1, START_FRAMES=4: exactly 4 frames with word0=B7BC and words A5A5,5A5A,C3C3, then run=1 on a frame boundary.
- In RUN, comp_dat=48'h123456789ABC at dat_ack: next frame is 50BC, 9ABC, 5678, 1234, with word1 appearing 3 clocks after dat_ack.
- fc_req pulse at phase 1, then inj_err with fc_req together later: one frame has FCBC header; a later frame has both FCBC and word1 bit 0 inverted; neighbouring frames are normal.
- prbs_en=1: words1-3 match the reference PRBS-15 sequence from seed 7FFF; after drop/restore of tx_enable the sequence restarts at seed after a fresh START.
- tx_ready drops at phase 1 of a RUN frame: that frame completes intact and the next frame is IDLE; frame_count holds its value; rst_n low mid-frame immediately forces the reset outputs.
